// File: rtl/uart_rx_frontend.sv
// Oversampling 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote,
// glitch/framing/break handling, and a 1-entry valid/ready hold register.
module uart_rx_frontend #(
    parameter int CLK_DIV    = 651,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_A       = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B       = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V       = SW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rx_s_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [SW-1:0]   scnt_q, scnt_d, scnt_adv;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            tick, vote, deliver, hs;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        scnt_d   = scnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        smp_a_d  = smp_a_q;
        smp_b_d  = smp_b_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = ovr_q;
        deliver  = 1'b0;

        tick     = (tcnt_q == TICK_LAST);
        tcnt_d   = tick ? '0 : tcnt_q + 1'b1;
        scnt_adv = (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;
        // Third sample is the live line value on the vote tick itself.
        vote     = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);

        if (tick) begin
            if (scnt_q == S_A) smp_a_d = rx_s_q;
            if (scnt_q == S_B) smp_b_d = rx_s_q;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        scnt_d  = '0;
                    end
                end
                START: begin
                    scnt_d = scnt_adv;
                    if (scnt_q == S_V && vote) begin
                        state_d = IDLE;
                    end else if (scnt_q == S_LAST) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    scnt_d = scnt_adv;
                    if (scnt_q == S_V) shift_d = {vote, shift_q[7:1]};
                    if (scnt_q == S_LAST) begin
                        if (bitcnt_q == 3'd7) state_d = STOP;
                        else                  bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                STOP: begin
                    scnt_d = scnt_adv;
                    // Decide mid-bit so a start bit right after the stop bit is seen.
                    if (scnt_q == S_V) begin
                        deliver = vote;
                        ferr_d  = ~vote;
                        state_d = vote ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        hs = valid_q & rx_ready;
        if (hs)      valid_d = 1'b0;
        if (err_clr) ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || hs) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            state_q  <= IDLE;
            tcnt_q   <= '0;
            scnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            smp_a_q  <= 1'b0;
            smp_b_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= rx;
            rx_s_q   <= sync1_q;
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            scnt_q   <= scnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            smp_a_q  <= smp_a_d;
            smp_b_q  <= smp_b_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed and random 8N1 frames checked against a
// frame-level model of the hold register, overrun flag and framing errors.
module tb_uart_rx_frontend;

    localparam int CLK_DIV = 4;
    localparam int OVS     = 16;
    localparam int BIT     = CLK_DIV * OVS;

    logic       sysclk, reset, rx, rx_ready, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    uart_rx_frontend #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OVS)) dut (
        .sysclk(sysclk), .reset(reset), .rx(rx), .rx_ready(rx_ready),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .overrun(overrun)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_cmp = 0, n_err = 0;
    int vcyc = 0, fecyc = 0;
    logic [7:0] acc_q[$];

    // Observed side: every byte actually handed over, and cycles of valid / frame_err.
    always @(negedge sysclk) begin
        if (!reset) begin
            if (rx_valid) vcyc <= vcyc + 1;
            if (frame_err) fecyc <= fecyc + 1;
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        end
    end

    // Reference model at frame granularity.
    logic       m_valid = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_hold = 8'h00;
    int         exp_fe = 0, rd_idx = 0;
    logic [7:0] exp_acc[$];

    task automatic step(input int n);
        repeat (n) begin @(posedge sysclk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        rx_ready = v;
        if (v && m_valid) begin
            exp_acc.push_back(m_hold);
            m_valid = 1'b0;
        end
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (rx_ready)      exp_acc.push_back(b);
        else if (!m_valid) begin m_valid = 1'b1; m_hold = b; end
        else               m_ovr = 1'b1;
    endtask

    // inv flips a 4-cycle window that contains exactly one of the three mid-bit samples.
    task automatic send_bit(input logic v, input bit inv);
        for (int c = 0; c < BIT; c++) begin
            rx = v ^ (inv && c >= 34 && c <= 37);
            step(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit inv);
        send_bit(1'b0, inv);
        for (int i = 0; i < 8; i++) send_bit(b[i], inv);
        send_bit(stop, inv);
        if (stop) model_deliver(b);
        else      exp_fe++;
    endtask

    task automatic hold_line(input logic v, input int nbits);
        rx = v;
        step(nbits * BIT);
    endtask

    task automatic drain();
        set_ready(1'b1);
        step(2);
        set_ready(1'b0);
    endtask

    task automatic chk_state(input string t);
        chk({t, ":valid"}, 32'(rx_valid), 32'(m_valid));
        if (m_valid) chk({t, ":data"}, 32'(rx_data), 32'(m_hold));
        chk({t, ":overrun"}, 32'(overrun), 32'(m_ovr));
        chk({t, ":frame_err_cycles"}, 32'(fecyc), 32'(exp_fe));
        chk({t, ":accepted_count"}, 32'(acc_q.size()), 32'(exp_acc.size()));
        for (int i = rd_idx; i < exp_acc.size(); i++)
            chk({t, ":accepted_byte"}, (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hxxxx_xxxx,
                32'(exp_acc[i]));
        rd_idx = exp_acc.size();
    endtask

    initial begin
        logic [7:0] b;
        logic       rdy, stp;
        bit         inv;
        int         v0;

        rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0; reset = 1'b1;
        step(5);
        chk("reset:rx_valid", 32'(rx_valid), 32'd0);
        chk("reset:rx_data", 32'(rx_data), 32'd0);
        chk("reset:frame_err", 32'(frame_err), 32'd0);
        chk("reset:overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step(BIT);

        // 1: byte held until accepted, then valid drops after one handshake cycle
        send_frame(8'hA5, 1'b1, 1'b0);
        chk_state("t1");
        step($urandom_range(5, 50));
        chk("t1:held_valid", 32'(rx_valid), 32'd1);
        chk("t1:held_data", 32'(rx_data), 32'hA5);
        set_ready(1'b1);
        step(1);
        set_ready(1'b0);
        chk("t1:valid_after_accept", 32'(rx_valid), 32'd0);
        chk_state("t1b");

        // 2: short low glitch, then a frame with one corrupted sample per bit
        rx = 1'b0; step(8); rx = 1'b1; step(2 * BIT);
        chk_state("t2_glitch");
        send_frame(8'h3C, 1'b1, 1'b1);
        chk_state("t2_vote");
        drain();

        // 3: bad stop bit, held break, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        hold_line(1'b0, 5);
        hold_line(1'b1, 2);
        send_frame(8'h81, 1'b1, 1'b0);
        chk_state("t3");
        drain();

        // 4: overrun with back-to-back frames, then clear
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk_state("t4_ovr");
        err_clr = 1'b1; step(1); err_clr = 1'b0; m_ovr = 1'b0;
        chk_state("t4_clr");
        drain();

        // 5: consumer always ready, back-to-back frames
        set_ready(1'b1);
        step(2);
        v0 = vcyc;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        step(4);
        chk("t5:valid_cycles", 32'(vcyc - v0), 32'd2);
        chk_state("t5");
        set_ready(1'b0);

        // 6: reset during data bit 4 of 0x77. The tail stops after bit 6: a low
        // bit 7 after reset would legitimately look like a fresh start bit.
        b = 8'h77;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        rx = b[4]; step(20);
        reset = 1'b1; step(1); reset = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0;
        step(BIT - 21);
        send_bit(b[5], 1'b0);
        send_bit(b[6], 1'b0);
        hold_line(1'b1, 3);
        chk_state("t6_abort");
        send_frame(8'h5A, 1'b1, 1'b0);
        chk_state("t6_next");
        drain();

        // Random frames: random data, consumer readiness, noise, bad stops, gaps
        for (int k = 0; k < 12; k++) begin
            b   = 8'($urandom);
            rdy = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 5) != 0);
            inv = 1'($urandom_range(0, 1));
            set_ready(rdy);
            step(1);
            send_frame(b, stp, inv);
            if (!stp) begin
                hold_line(1'b0, $urandom_range(0, 2));
                hold_line(1'b1, 1);
            end else begin
                rx = 1'b1;
                step($urandom_range(0, 100));
            end
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1; step(1); err_clr = 1'b0; m_ovr = 1'b0;
            end
            chk_state("rand");
        end
        drain();
        err_clr = 1'b1; step(1); err_clr = 1'b0; m_ovr = 1'b0;
        step(4);
        chk_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
